// File: rtl/axis_mc_pkg.sv
// Shared types and helpers for the multi-channel AXI-Stream FIFO adapter.
// Widths derive from each instance's parameters, so they are functions here.
package axis_mc_pkg;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_e;

  function automatic int keep_w(input int w);
    return w / 8;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // First set bit of elig strictly after last, wrapping modulo n.
  function automatic logic [3:0] rr_next(
    input logic [15:0] elig,
    input logic [3:0]  last,
    input int          n
  );
    logic [3:0] r;
    int idx;
    r = last;
    for (int i = 16; i >= 1; i--) begin
      if (i <= n) begin
        idx = (int'(last) + i) % n;
        if (elig[idx]) r = 4'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_mc_chan_buf.sv
// One channel: narrow-to-wide packer, FIFO with registered head,
// and complete-frame counter.
module axis_mc_chan_buf
  import axis_mc_pkg::*;
#(
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 8,
  parameter int DEPTH        = 64,
  parameter int USER_WIDTH   = 1,
  parameter int FRAME_FIFO   = 0,
  localparam int KEEP_S = keep_w(S_DATA_WIDTH),
  localparam int M_W    = S_DATA_WIDTH * RATIO,
  localparam int KEEP_M = keep_w(M_W),
  localparam int PTR_W  = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [S_DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KEEP_S-1:0]     s_tkeep_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  input  logic [USER_WIDTH-1:0] s_tuser_i,
  output logic                  s_tready_o,
  input  logic                  pop_i,
  output logic [M_W-1:0]        head_data_o,
  output logic [KEEP_M-1:0]     head_keep_o,
  output logic [USER_WIDTH-1:0] head_user_o,
  output logic                  head_last_o,
  output logic                  head_vld_o,
  output logic                  elig_o,
  output logic [PTR_W:0]        fill_o
);

  localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int EW     = M_W + KEEP_M + USER_WIDTH + 1;

  logic [SLOT_W-1:0]     slot_q;
  logic [M_W-1:0]        acc_data_q, pk_data;
  logic [KEEP_M-1:0]     acc_keep_q, pk_keep;
  logic [USER_WIDTH-1:0] acc_user_q, pk_user;
  logic [PTR_W:0]        wr_q, rd_q, rd_d, fcnt_q;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [EW-1:0]         head_q;
  logic                  hv_q, rdy_q;
  logic                  full, acc, wr, fin, fout;

  assign fill_o     = wr_q - rd_q;
  assign full       = fill_o == (PTR_W+1)'(DEPTH);
  assign s_tready_o = rdy_q && !full;
  assign acc        = s_tvalid_i && s_tready_o;
  assign wr         = acc &&
                      (s_tlast_i || slot_q == SLOT_W'(RATIO - 1));
  assign rd_d       = rd_q + (PTR_W+1)'(pop_i);

  always_comb begin
    pk_data = acc_data_q;
    pk_keep = acc_keep_q;
    pk_data[slot_q*S_DATA_WIDTH +: S_DATA_WIDTH] = s_tdata_i;
    pk_keep[slot_q*KEEP_S +: KEEP_S] = s_tkeep_i;
    pk_user = acc_user_q | s_tuser_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      slot_q     <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_user_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (wr) begin
        slot_q     <= '0;
        acc_data_q <= '0;
        acc_keep_q <= '0;
        acc_user_q <= '0;
      end else if (acc) begin
        slot_q     <= slot_q + 1'b1;
        acc_data_q <= pk_data;
        acc_keep_q <= pk_keep;
        acc_user_q <= pk_user;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q[PTR_W-1:0]] <=
      {s_tlast_i, pk_user, pk_keep, pk_data};
  end

  // Head is refilled only from entries written on an earlier edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hv_q   <= 1'b0;
      head_q <= '0;
    end else begin
      wr_q <= wr_q + (PTR_W+1)'(wr);
      rd_q <= rd_d;
      hv_q <= wr_q != rd_d;
      if (wr_q != rd_d) head_q <= mem_q[rd_d[PTR_W-1:0]];
    end
  end

  assign head_data_o = head_q[M_W-1:0];
  assign head_keep_o = head_q[M_W +: KEEP_M];
  assign head_user_o = head_q[EW-2 -: USER_WIDTH];
  assign head_last_o = head_q[EW-1];
  assign head_vld_o  = hv_q;

  assign fin  = wr && s_tlast_i;
  assign fout = pop_i && head_last_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else if (fin && !fout) begin
      fcnt_q <= fcnt_q + 1'b1;
    end else if (fout && !fin) begin
      fcnt_q <= fcnt_q - 1'b1;
    end
  end

  // A full FIFO without a whole frame must still drain (cut-through).
  assign elig_o = (FRAME_FIFO != 0) ? (fcnt_q != '0 || full) : hv_q;

endmodule

// File: rtl/axis_mc_fifo_adapter.sv
// Multi-channel AXI-Stream upsizing FIFO with frame-granular
// round-robin merge onto one wide output.
module axis_mc_fifo_adapter
  import axis_mc_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int S_DATA_WIDTH = 8,
  parameter int RATIO        = 8,
  parameter int M_DATA_WIDTH = S_DATA_WIDTH * RATIO,
  parameter int DEPTH        = 64,
  parameter int USER_WIDTH   = 1,
  parameter int FRAME_FIFO   = 0,
  parameter int ID_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int KEEP_S = keep_w(S_DATA_WIDTH),
  localparam int KEEP_M = keep_w(M_DATA_WIDTH),
  localparam int FW     = ptr_w(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS*KEEP_S-1:0]     s_axis_tkeep,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_M-1:0]              m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic [CHANNELS*FW-1:0]         fill_level
);

  logic [M_DATA_WIDTH-1:0] hd [CHANNELS];
  logic [KEEP_M-1:0]       hk [CHANNELS];
  logic [USER_WIDTH-1:0]   hu [CHANNELS];
  logic [CHANNELS-1:0]     hl, hv, elig, pop;
  arb_state_e              st_q;
  logic [ID_WIDTH-1:0]     grant_q, last_q;
  logic                    vld;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign pop[c] = (st_q == XFER) && grant_q == ID_WIDTH'(c) &&
                    hv[c] && m_axis_tready;

    axis_mc_chan_buf #(
      .S_DATA_WIDTH (S_DATA_WIDTH),
      .RATIO        (RATIO),
      .DEPTH        (DEPTH),
      .USER_WIDTH   (USER_WIDTH),
      .FRAME_FIFO   (FRAME_FIFO)
    ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_tdata_i   (s_axis_tdata[c*S_DATA_WIDTH +: S_DATA_WIDTH]),
      .s_tkeep_i   (s_axis_tkeep[c*KEEP_S +: KEEP_S]),
      .s_tvalid_i  (s_axis_tvalid[c]),
      .s_tlast_i   (s_axis_tlast[c]),
      .s_tuser_i   (s_axis_tuser[c*USER_WIDTH +: USER_WIDTH]),
      .s_tready_o  (s_axis_tready[c]),
      .pop_i       (pop[c]),
      .head_data_o (hd[c]),
      .head_keep_o (hk[c]),
      .head_user_o (hu[c]),
      .head_last_o (hl[c]),
      .head_vld_o  (hv[c]),
      .elig_o      (elig[c]),
      .fill_o      (fill_level[c*FW +: FW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(CHANNELS - 1);
    end else begin
      unique case (st_q)
        IDLE: if (|elig) begin
          grant_q <= ID_WIDTH'(rr_next(16'(elig), 4'(last_q), CHANNELS));
          st_q    <= XFER;
        end
        XFER: if (vld && m_axis_tready && hl[grant_q]) begin
          st_q   <= IDLE;
          last_q <= grant_q;
        end
      endcase
    end
  end

  assign vld           = (st_q == XFER) && hv[grant_q];
  assign m_axis_tvalid = vld;
  assign m_axis_tdata  = vld ? hd[grant_q] : '0;
  assign m_axis_tkeep  = vld ? hk[grant_q] : '0;
  assign m_axis_tuser  = vld ? hu[grant_q] : '0;
  assign m_axis_tlast  = vld && hl[grant_q];
  assign m_axis_tid    = vld ? grant_q : '0;

endmodule

// File: tb/tb_axis_mc_fifo_adapter.sv
// Bench for axis_mc_fifo_adapter: a streaming instance and a frame-mode
// instance, both DEPTH=4, checked against a packer model scoreboard.
module tb_axis_mc_fifo_adapter;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sd [2];
  logic [3:0]  sk [2], sv [2], sl [2], su [2], st [2];
  logic [63:0] md [2];
  logic [7:0]  mk [2];
  logic        mv [2], mr [2], ml [2], mu [2];
  logic [1:0]  mid [2];
  logic [11:0] fl [2];

  axis_mc_fifo_adapter #(
    .CHANNELS(4), .S_DATA_WIDTH(8), .RATIO(8), .DEPTH(4),
    .USER_WIDTH(1), .FRAME_FIFO(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(sd[0]), .s_axis_tkeep(sk[0]),
    .s_axis_tvalid(sv[0]), .s_axis_tready(st[0]),
    .s_axis_tlast(sl[0]), .s_axis_tuser(su[0]),
    .m_axis_tdata(md[0]), .m_axis_tkeep(mk[0]),
    .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]),
    .m_axis_tlast(ml[0]), .m_axis_tid(mid[0]),
    .m_axis_tuser(mu[0]), .fill_level(fl[0])
  );

  axis_mc_fifo_adapter #(
    .CHANNELS(4), .S_DATA_WIDTH(8), .RATIO(8), .DEPTH(4),
    .USER_WIDTH(1), .FRAME_FIFO(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(sd[1]), .s_axis_tkeep(sk[1]),
    .s_axis_tvalid(sv[1]), .s_axis_tready(st[1]),
    .s_axis_tlast(sl[1]), .s_axis_tuser(su[1]),
    .m_axis_tdata(md[1]), .m_axis_tkeep(mk[1]),
    .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]),
    .m_axis_tlast(ml[1]), .m_axis_tid(mid[1]),
    .m_axis_tuser(mu[1]), .fill_level(fl[1])
  );

  int n_chk = 0;
  int n_err = 0;
  beat_t exp_q [8][$];
  int obs_q [$];
  logic [63:0] pd [8];
  logic [7:0]  pk [8];
  logic        pu [8];
  int          ps [8];
  logic infr [2];
  logic gap_on [2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < 8; i++) begin
      exp_q[i].delete();
      pd[i] = '0;
      pk[i] = '0;
      pu[i] = 1'b0;
      ps[i] = 0;
    end
  endfunction

  function automatic void mdl_push(input int i, input logic [7:0] b,
                                   input logic last, input logic u);
    beat_t e;
    pd[i][ps[i]*8 +: 8] = b;
    pk[i][ps[i]] = 1'b1;
    pu[i] = pu[i] | u;
    if (last || ps[i] == 7) begin
      e.d = pd[i];
      e.k = pk[i];
      e.l = last;
      e.u = pu[i];
      exp_q[i].push_back(e);
      pd[i] = '0;
      pk[i] = '0;
      pu[i] = 1'b0;
      ps[i] = 0;
    end else begin
      ps[i]++;
    end
  endfunction

  task automatic send(input int d, input int ch, input logic [7:0] b,
                      input logic last);
    logic ok;
    logic u;
    ok = 1'b0;
    u = (b[3:0] == 4'h5);
    sd[d][ch*8 +: 8] = b;
    sk[d][ch] = 1'b1;
    sl[d][ch] = last;
    su[d][ch] = u;
    sv[d][ch] = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (st[d][ch]) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    #1;
    sv[d][ch] = 1'b0;
    chk("s_tready wait", 64'(ok), 64'(1));
    if (ok) mdl_push(d*4 + ch, b, last, u);
  endtask

  task automatic drain(input int d);
    logic empty;
    empty = 1'b0;
    for (int n = 0; n < 500 && !empty; n++) begin
      empty = 1'b1;
      for (int i = 0; i < 4; i++)
        if (exp_q[d*4 + i].size() != 0) empty = 1'b0;
      if (!empty) @(posedge clk);
    end
    chk("drain", 64'(empty), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int g);
    beat_t e;
    int i;
    if (!rst_n) begin
      infr[g] = 1'b0;
      return;
    end
    if (gap_on[g] && infr[g]) chk("gap", 64'(mv[g]), 64'(1));
    if (mv[g] && mr[g]) begin
      i = g*4 + int'(mid[g]);
      if (g == 0) obs_q.push_back(int'(mid[g]));
      chk("beat expected", 64'(exp_q[i].size() != 0), 64'(1));
      if (exp_q[i].size() != 0) begin
        e = exp_q[i].pop_front();
        chk("tdata", md[g], e.d);
        chk("tkeep", 64'(mk[g]), 64'(e.k));
        chk("tlast", 64'(ml[g]), 64'(e.l));
        chk("tuser", 64'(mu[g]), 64'(e.u));
      end
      infr[g] = !ml[g];
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      sd[d] = '0; sk[d] = '0; sv[d] = '0; sl[d] = '0; su[d] = '0;
      mr[d] = 1'b0; infr[d] = 1'b0; gap_on[d] = 1'b0;
    end
    mdl_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst tvalid", 64'(mv[0]), 64'(0));
    chk("rst tdata", md[0], 64'(0));
    chk("rst s_tready", 64'(st[0]), 64'(0));
    chk("rst fill", 64'(fl[1]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_tready pre-edge", 64'(st[0]), 64'(0));
    @(posedge clk);
    #1;
    chk("s_tready up0", 64'(st[0]), 64'hF);
    chk("s_tready up1", 64'(st[1]), 64'hF);

    // packing: 10 bytes -> full beat + 2-byte tail
    mr[0] = 1'b1;
    mr[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int b = 1; b <= 10; b++) send(d, 0, 8'(b), b == 10);
      drain(d);
    end

    // latency from beat-completing handshake to tvalid
    for (int b = 0; b < 8; b++) send(0, 1, 8'(8'h10 + b), b == 7);
    chk("lat t", 64'(mv[0]), 64'(0));
    @(posedge clk);
    #1;
    chk("lat t+1", 64'(mv[0]), 64'(0));
    @(posedge clk);
    #1;
    chk("lat t+2", 64'(mv[0]), 64'(1));
    chk("lat tid", 64'(mid[0]), 64'(1));
    drain(0);

    // round robin
    mr[0] = 1'b0;
    for (int c = 0; c < 4; c++) send(0, c, 8'(8'h20 + c), 1'b1);
    obs_q.delete();
    mr[0] = 1'b1;
    drain(0);
    chk("rr count", 64'(obs_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk("rr order", 64'(obs_q[i]), 64'(i));
    mr[0] = 1'b0;
    send(0, 1, 8'h31, 1'b1);
    send(0, 3, 8'h33, 1'b1);
    obs_q.delete();
    mr[0] = 1'b1;
    drain(0);
    chk("rr2 count", 64'(obs_q.size()), 64'(2));
    if (obs_q.size() == 2) begin
      chk("rr2 first", 64'(obs_q[0]), 64'(1));
      chk("rr2 second", 64'(obs_q[1]), 64'(3));
    end

    // backpressure on a DEPTH=4 channel
    mr[0] = 1'b0;
    for (int b = 0; b < 32; b++) send(0, 2, 8'(8'h40 + b), 1'b0);
    chk("bp s_tready", 64'(st[0][2]), 64'(0));
    chk("bp fill", 64'(fl[0][8:6]), 64'(4));
    chk("bp other ready", 64'(st[0][1]), 64'(1));
    mr[0] = 1'b1;
    for (int b = 32; b < 40; b++) send(0, 2, 8'(8'h40 + b), b == 39);
    drain(0);

    // frame mode: held until tlast, then contiguous
    for (int b = 0; b < 24; b++) send(1, 1, 8'(8'h60 + b), 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("frame hold", 64'(mv[1]), 64'(0));
    gap_on[1] = 1'b1;
    send(1, 1, 8'h78, 1'b1);
    drain(1);
    gap_on[1] = 1'b0;

    // oversize frame: cut-through when full without a whole frame
    for (int b = 0; b < 48; b++) send(1, 0, 8'(8'h80 + b), b == 47);
    drain(1);

    // asynchronous reset mid-frame with data buffered
    mr[0] = 1'b0;
    for (int b = 0; b < 12; b++) send(0, 3, 8'(8'hA0 + b), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst tvalid", 64'(mv[0]), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst tvalid", 64'(mv[0]), 64'(0));
    chk("mid-rst tdata", md[0], 64'(0));
    chk("mid-rst tid", 64'(mid[0]), 64'(0));
    chk("mid-rst s_tready", 64'(st[0]), 64'(0));
    chk("mid-rst fill", 64'(fl[0]), 64'(0));
    mdl_clear();
    @(negedge clk);
    rst_n = 1'b1;
    mr[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post-rst fill", 64'(fl[0]), 64'(0));
    chk("post-rst tvalid", 64'(mv[0]), 64'(0));
    chk("post-rst s_tready", 64'(st[0]), 64'hF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axis_mc_fifo_adapter.md
Name: axis_mc_fifo_adapter

Overview:
Single-clock, multi-channel AXI4-Stream FIFO with width upsizing.
- CHANNELS independent narrow input streams are each packed to M_DATA_WIDTH and buffered in a per-channel FIFO.
- The channels are merged onto one wide output by a frame-granular round-robin arbiter. tid carries the source channel.
- Sits between per-port MAC receive logic and the wide DMA/host stream.

Parameters:
- CHANNELS, 4: number of input streams (1..16).
- S_DATA_WIDTH, 8: input data width per channel; word size is 8 bits.
- RATIO, 8: output/input width ratio; power of two, 1..16.
- M_DATA_WIDTH, S_DATA_WIDTH*RATIO: output data width (derived; do not override).
- DEPTH, 64: per-channel FIFO depth in output beats; power of two, 4 minimum.
- USER_WIDTH, 1: tuser width.
- FRAME_FIFO, 0: 1 = a channel is eligible only when it holds a complete frame.
- ID_WIDTH, max(1,$clog2(CHANNELS)): tid width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  CHANNELS*S_DATA_WIDTH  flattened per-channel data; channel c at slice c.
- s_axis_tkeep  in  CHANNELS*(S_DATA_WIDTH/8)  per-channel byte enables.
- s_axis_tvalid  in  CHANNELS  per-channel valid.
- s_axis_tready  out  CHANNELS  per-channel ready.
- s_axis_tlast  in  CHANNELS  per-channel end of frame.
- s_axis_tuser  in  CHANNELS*USER_WIDTH  per-channel user.
- m_axis_tdata  out  M_DATA_WIDTH  output data.
- m_axis_tkeep  out  M_DATA_WIDTH/8  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tid  out  ID_WIDTH  source channel index.
- m_axis_tuser  out  USER_WIDTH  user.
- fill_level  out  CHANNELS*($clog2(DEPTH)+1)  per-channel FIFO occupancy in beats.

Behaviour:
- Reset: rst_n low asynchronously clears all state.
  - Outputs: m_axis_tvalid=0, tdata/tkeep/tlast/tid/tuser=0, s_axis_tready=0, fill_level=0.
  - s_axis_tready rises on the first clk edge after rst_n deasserts.
  - Partial frames and buffered data are discarded. No output is produced until new input arrives.
- Packer (per channel):
  - Slot counter 0..RATIO-1. An accepted input word is stored at slot position (slot 0 = LSBs).
  - A beat is emitted to the FIFO on acceptance at slot RATIO-1, or on acceptance with tlast.
  - Unfilled slots of an emitted beat: data=0, keep=0.
  - tuser of the beat = OR of tuser over the words packed into it. tlast is copied. Slot counter then returns to 0.
  - s_axis_tready[c] = !fifo_full[c]. Every accepted word is therefore guaranteed to fit.
- FIFO (per channel): DEPTH entries with registered head.
  - fill_level updates the cycle after a write/read.
  - Simultaneous write and read leaves fill unchanged.
  - Pointers wrap modulo DEPTH, using an extra MSB for full/empty.
- Eligibility:
  - FRAME_FIFO=0: channel eligible if its FIFO is non-empty.
  - FRAME_FIFO=1: channel eligible if its complete-frame count is >0.
    - Count increments on a tlast beat write and decrements on a tlast beat read; simultaneous increment and decrement leaves it unchanged.
    - Oversize rule: FIFO full with count 0 also makes the channel eligible (cut-through), which prevents deadlock.
- Arbiter FSM: IDLE, XFER.
  - IDLE: choose the first eligible channel after last_grant (round-robin, wrapping), register grant and tid, go to XFER. Nothing eligible: stay in IDLE.
  - XFER: drive m_axis_* from the head of the granted FIFO. m_axis_tvalid = FIFO non-empty.
  - On handshake with tlast: return to IDLE, update last_grant. This inserts one idle cycle between frames.
  - Grant never changes mid-frame. Other channels keep filling while one channel is in XFER.
- Latency (FRAME_FIFO=0, arbiter idle): input handshake completing a beat at edge t gives m_axis_tvalid high after edge t+2.
- Output is stable while tvalid=1 and tready=0.

Decomposition:
- Package axis_mc_pkg holds:
  - the arbiter state enum (IDLE, XFER);
  - constants KEEP_S=S_DATA_WIDTH/8, KEEP_M=M_DATA_WIDTH/8, PTR_W=$clog2(DEPTH);
  - the round-robin next-index function.
- One sub-module, axis_mc_chan_buf: packer, FIFO and frame counter for one channel. Instantiated CHANNELS times in a generate loop. The top holds the arbiter and output mux.

Test Plan:
- Reset: assert rst_n=0 mid-frame with data buffered -> all outputs 0 immediately; after release, fill_level=0 and no beat emitted.
- Packing, CHANNELS=4, RATIO=8: ch0 sends 10 bytes 0x01..0x0A with tlast on 0x0A -> two beats, tid=0. Beat 1: keep=0xFF, data 0x0807060504030201, tlast=0. Beat 2: keep=0x03, data 0x0A09, tlast=1.
- Round-robin: ch0..ch3 each hold one 1-beat frame -> output order tid 0,1,2,3; then ch1 and ch3 refill -> order 1,3 after last_grant=3 wraps.
- Backpressure, DEPTH=4: m_axis_tready=0, ch2 sends 40 bytes -> s_axis_tready[2] drops after 32 bytes, fill_level[2]=4. Releasing tready resumes input with no data lost.
- Frame mode, FRAME_FIFO=1: ch1 sends 3 beats without tlast -> m_axis_tvalid stays 0; tlast arrives -> frame output contiguous, tvalid not deasserted mid-frame.
- Oversize, FRAME_FIFO=1, DEPTH=4: ch0 sends a 6-beat frame -> FIFO fills, cut-through grant; all 6 beats delivered in order with tlast on the 6th.
